// File: rtl/piled_counter_pkg.sv
// piled_counter_pkg: board geometry and packed-count field helpers
package piled_counter_pkg;
  localparam int COL_COUNT = 7;
  localparam int ROW_COUNT = 6;
  localparam int COL_SIZE = 3;
  localparam int ROW_SIZE = 3;
  localparam int PILED_COUNT_ARRAY_SIZE = COL_COUNT * ROW_SIZE;
  typedef logic [ROW_SIZE-1:0] count_t;
  typedef logic [COL_SIZE-1:0] col_t;
  typedef logic [PILED_COUNT_ARRAY_SIZE-1:0] pile_t;
  // Loops keep out-of-range columns from indexing past the array; they yield 0
  function automatic count_t get_field(pile_t a, col_t c);
    count_t r;
    r = '0;
    for (int i = 0; i < COL_COUNT; i++)
      if (col_t'(i) == c) r = a[i*ROW_SIZE +: ROW_SIZE];
    return r;
  endfunction
  function automatic pile_t set_field(pile_t a, col_t c, count_t v);
    pile_t r;
    r = a;
    for (int i = 0; i < COL_COUNT; i++)
      if (col_t'(i) == c) r[i*ROW_SIZE +: ROW_SIZE] = v;
    return r;
  endfunction
endpackage

// File: rtl/piled_counter_comb.sv
// piled_counter_comb: next-value logic for one drop (extract, compare, increment, splice)
module piled_counter_comb
  import piled_counter_pkg::*;
(
  input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_arr,
  input  logic [COL_SIZE-1:0]               i_col,
  output logic                              o_valid,
  output logic [ROW_SIZE-1:0]               o_count,
  output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_arr
);
  logic   in_range;
  count_t cnt;
  always_comb begin
    in_range = i_col < col_t'(COL_COUNT);
    cnt = get_field(i_arr, i_col);
    o_valid = in_range && (cnt < count_t'(ROW_COUNT));
    o_count = in_range ? cnt : '0;
    o_arr = o_valid ? set_field(i_arr, i_col, cnt + count_t'(1)) : i_arr;
  end
endmodule

// File: rtl/piled_counter.sv
// piled_counter: registered per-column stack-height tracker for the drop-game board
module piled_counter
  import piled_counter_pkg::*;
(
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_count_array,
  input  logic [COL_SIZE-1:0]               i_col,
  output logic                              o_valid,
  output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_counter,
  output logic [ROW_SIZE-1:0]               o_piled_count
);
  logic   valid_d, valid_q;
  count_t count_d, count_q;
  pile_t  arr_d, arr_q;
  piled_counter_comb u_comb (
    .i_arr   (i_piled_count_array),
    .i_col   (i_col),
    .o_valid (valid_d),
    .o_count (count_d),
    .o_arr   (arr_d)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      count_q <= '0;
      arr_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      arr_q <= arr_d;
    end
  end
  assign o_valid = valid_q;
  assign o_piled_count = count_q;
  assign o_piled_counter = arr_q;
endmodule

// File: tb/tb_piled_counter.sv
// tb_piled_counter: scoreboard bench with directed, random and feedback-loop stimulus
module tb_piled_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] i_arr = '0;
  logic [2:0]  i_col = '0;
  logic        o_valid;
  logic [20:0] o_piled_counter;
  logic [2:0]  o_piled_count;
  int checks = 0;
  int passes = 0;
  typedef struct {
    logic        v;
    logic [2:0]  c;
    logic [20:0] a;
  } exp_t;
  exp_t q[$];

  piled_counter dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_piled_count_array (i_arr),
    .i_col               (i_col),
    .o_valid             (o_valid),
    .o_piled_counter     (o_piled_counter),
    .o_piled_count       (o_piled_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0o expected %0o", name, act, exp);
  endtask

  // Reference: unpack to per-column integers, apply the drop rule, repack
  function automatic exp_t model(logic [20:0] arr, int col);
    int f[7];
    exp_t e;
    for (int i = 0; i < 7; i++) f[i] = int'((arr >> (3*i)) & 21'd7);
    e.a = arr;
    e.v = 1'b0;
    e.c = 3'd0;
    if (col < 7) begin
      e.c = 3'(f[col]);
      if (f[col] < 6) begin
        e.v = 1'b1;
        f[col] = f[col] + 1;
        e.a = '0;
        for (int i = 0; i < 7; i++) e.a = e.a | 21'(f[i] << (3*i));
      end
    end
    return e;
  endfunction

  task automatic drive(logic [20:0] arr, int col);
    i_arr = arr;
    i_col = 3'(col);
    q.push_back(model(arr, col));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("o_valid", 32'(o_valid), 32'(e.v));
        chk("o_piled_count", 32'(o_piled_count), 32'(e.c));
        chk("o_piled_counter", 32'(o_piled_counter), 32'(e.a));
      end
    end
  end

  initial begin : stim
    logic [20:0] fb;
    logic [20:0] r;
    int waited;
    #1;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_count", 32'(o_piled_count), 32'd0);
    chk("reset_array", 32'(o_piled_counter), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(21'o0000000, 0);
    @(negedge clk); drive(21'o0003000, 3);
    @(negedge clk); drive(21'o6000000, 6);
    @(negedge clk); drive(21'o1234560, 7);
    @(negedge clk); drive(21'o0700000, 5);
    @(negedge clk); drive(21'o5555555, 2);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      r = 21'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int i = 0; i < 7; i++) r[3*i +: 3] = 3'($urandom_range(0, 6));
      drive(r, int'($urandom_range(0, 7)));
    end
    // Asynchronous reset mid-run, between clock edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(o_valid), 32'd0);
    chk("async_reset_count", 32'(o_piled_count), 32'd0);
    chk("async_reset_array", 32'(o_piled_counter), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(21'o0000010, 1);
    // Feedback loop: write o_piled_counter back whenever o_valid is set
    fb = '0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (n > 0 && o_valid) fb = o_piled_counter;
      drive(fb, n % 7);
    end
    @(negedge clk);
    if (o_valid) fb = o_piled_counter;
    chk("feedback_saturated", 32'(fb), 32'(21'o6666666));
    chk("feedback_final_valid", 32'(o_valid), 32'd0);
    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
